// File: rtl/bist_pkg.sv
// Shared definitions for the BIST vector engine: controller states, default
// polynomials and the Galois shift step used by both the LFSR and the MISR.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          MAX_SHREG_W   = 64;
    localparam logic [35:0] DEF_LFSR_POLY = 36'h800000C00;
    localparam logic [38:0] DEF_MISR_POLY = 39'h4000000011;

    // Operands are zero-extended into 64 bits, so the right shift always feeds
    // a zero into the register's own MSB; callers truncate back to their width.
    function automatic logic [MAX_SHREG_W-1:0] galois_step(
        input logic [MAX_SHREG_W-1:0] value,
        input logic [MAX_SHREG_W-1:0] poly
    );
        return (value >> 1) ^ (value[0] ? poly : {MAX_SHREG_W{1'b0}});
    endfunction

endpackage

// File: rtl/galois_shreg.sv
// Galois shift register with parallel input: serves as a stimulus LFSR (din
// tied low) or as a MISR compacting din. Priority is reset, clear, load, step.
module galois_shreg
    import bist_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] POLY = '0
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;
    logic [W-1:0] step_val;

    assign step_val = W'(galois_step(MAX_SHREG_W'(q_reg), MAX_SHREG_W'(POLY)));

    always_comb begin
        q_next = q_reg;
        if (clear) begin
            q_next = '0;
        end else if (load) begin
            q_next = load_val;
        end else if (en) begin
            q_next = step_val ^ din;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/bist_vector_engine.sv
// Cycle-counted stimulus/response engine: drives LFSR or zero vectors into the
// netlist under test and compacts its outputs into a MISR signature.
module bist_vector_engine
    import bist_pkg::*;
#(
    parameter int              IN_W      = 36,
    parameter int              OUT_W     = 39,
    parameter logic [IN_W-1:0]  LFSR_POLY = IN_W'(DEF_LFSR_POLY),
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(DEF_MISR_POLY),
    parameter int              CNT_W     = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [IN_W-1:0]  seed,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [CNT_W-1:0] warmup,
    input  logic [OUT_W-1:0] exp_sig,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] vec_idx
);

    state_t           state_reg;
    state_t           state_next;
    logic             mode_reg;
    logic [CNT_W-1:0] num_vec_reg;
    logic [CNT_W-1:0] warmup_reg;
    logic [CNT_W-1:0] vec_idx_reg;

    logic             launch;
    logic             advance;
    logic             last_vec;
    logic             compact_en;
    logic [IN_W-1:0]  seed_eff;
    logic [IN_W-1:0]  lfsr_q;
    logic [OUT_W-1:0] misr_q;

    assign last_vec   = (vec_idx_reg == num_vec_reg - CNT_W'(1));
    assign compact_en = advance && (vec_idx_reg >= warmup_reg);
    // An all-zero seed would lock the LFSR at zero forever.
    assign seed_eff   = (seed == '0) ? '1 : seed;

    always_ff @(posedge CK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_next = (num_vec == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (last_vec) begin
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state_reg == RUN);
        done    = (state_reg == DONE);
        launch  = 1'b0;
        advance = 1'b0;
        if (!abort) begin
            launch  = start && (state_reg != RUN);
            advance = (state_reg == RUN);
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            mode_reg    <= 1'b0;
            num_vec_reg <= '0;
            warmup_reg  <= '0;
            vec_idx_reg <= '0;
        end else if (launch) begin
            mode_reg    <= mode;
            num_vec_reg <= num_vec;
            warmup_reg  <= warmup;
            vec_idx_reg <= '0;
        end else if (advance) begin
            vec_idx_reg <= vec_idx_reg + CNT_W'(1);
        end
    end

    galois_shreg #(
        .W    (IN_W),
        .POLY (LFSR_POLY)
    ) u_lfsr (
        .CK       (CK),
        .RST      (RST),
        .clear    (1'b0),
        .load     (launch),
        .load_val (seed_eff),
        .en       (advance),
        .din      ({IN_W{1'b0}}),
        .q        (lfsr_q)
    );

    galois_shreg #(
        .W    (OUT_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .CK       (CK),
        .RST      (RST),
        .clear    (launch),
        .load     (1'b0),
        .load_val ({OUT_W{1'b0}}),
        .en       (compact_en),
        .din      (resp),
        .q        (misr_q)
    );

    assign stim      = (busy && mode_reg) ? lfsr_q : '0;
    assign signature = misr_q;
    assign vec_idx   = vec_idx_reg;
    assign pass      = done && (misr_q == exp_sig);

endmodule

// File: tb/tb_bist_vector_engine.sv
// Self-checking bench for bist_vector_engine in a 4-bit configuration: a table
// of directed runs, hand-written abort/reset sequences and random runs.
module tb_bist_vector_engine;

    localparam logic [3:0] LP = 4'hC;
    localparam logic [3:0] MP = 4'hC;

    logic        CK;
    logic        RST;
    logic        start;
    logic        abort;
    logic        mode;
    logic [3:0]  seed;
    logic [15:0] num_vec;
    logic [15:0] warmup;
    logic [3:0]  exp_sig;
    logic [3:0]  stim;
    logic [3:0]  resp;
    logic        busy;
    logic        done;
    logic        pass;
    logic [3:0]  signature;
    logic [15:0] vec_idx;

    int checks   = 0;
    int failures = 0;

    bist_vector_engine #(
        .IN_W      (4),
        .OUT_W     (4),
        .LFSR_POLY (LP),
        .MISR_POLY (MP),
        .CNT_W     (16)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .seed      (seed),
        .num_vec   (num_vec),
        .warmup    (warmup),
        .exp_sig   (exp_sig),
        .stim      (stim),
        .resp      (resp),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .vec_idx   (vec_idx)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       m;
        logic [3:0] sd;
        int         nv;
        int         wu;
        int         rk;     // 0 = resp tied 0, 1 = resp looped back from stim
        logic [3:0] ex;
        logic [3:0] esig;
        logic       epass;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] step4(input logic [3:0] v, input logic [3:0] poly);
        return {1'b0, v[3:1]} ^ (v[0] ? poly : 4'h0);
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // One complete run from IDLE/DONE, checked every cycle against the model.
    task automatic run(input logic m, input logic [3:0] sd, input int nv, input int wu,
                       input logic [3:0] ex, input int rk, output logic [3:0] sig_out);
        logic [3:0] lf;
        logic [3:0] ms;
        logic [3:0] r;
        mode    = m;
        seed    = sd;
        num_vec = nv[15:0];
        warmup  = wu[15:0];
        exp_sig = ex;
        start   = 1'b1;
        tick();
        start = 1'b0;
        lf = (sd == 4'h0) ? 4'hF : sd;
        ms = 4'h0;
        for (int i = 0; i < nv; i++) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_vec_idx", 32'(vec_idx), 32'(i));
            chk("run_stim", 32'(stim), 32'(m ? lf : 4'h0));
            chk("run_signature", 32'(signature), 32'(ms));
            case (rk)
                0:       r = 4'h0;
                1:       r = stim;
                default: r = 4'($urandom_range(0, 15));
            endcase
            resp = r;
            if (i >= wu) ms = step4(ms, MP) ^ r;
            lf = step4(lf, LP);
            tick();
        end
        resp = 4'h0;
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_stim", 32'(stim), 32'd0);
        chk("end_vec_idx", 32'(vec_idx), 32'(nv));
        chk("end_signature", 32'(signature), 32'(ms));
        chk("end_pass", 32'(pass), 32'(ms == ex));
        sig_out = ms;
        $display("run mode=%0d seed=%h nv=%0d wu=%0d exp=%h sig=%h pass=%0b",
                 m, sd, nv, wu, ex, signature, pass);
    endtask

    initial begin
        logic [3:0] sig;
        logic [3:0] lf;
        logic [3:0] ms;
        logic [3:0] held;
        logic [3:0] seq1 [16];

        seq1 = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

        tbl[0] = '{1'b1, 4'h1, 16,  0,  0, 4'h0, 4'h0, 1'b1};
        tbl[1] = '{1'b1, 4'h1, 3,   0,  1, 4'h6, 4'h6, 1'b1};
        tbl[2] = '{1'b1, 4'h1, 3,   0,  1, 4'h5, 4'h6, 1'b0};
        tbl[3] = '{1'b0, 4'h5, 100, 0,  0, 4'h0, 4'h0, 1'b1};
        tbl[4] = '{1'b1, 4'h1, 3,   2,  1, 4'h6, 4'h6, 1'b1};
        tbl[5] = '{1'b1, 4'h1, 3,   5,  1, 4'h6, 4'h0, 1'b0};
        tbl[6] = '{1'b1, 4'h0, 1,   0,  1, 4'hF, 4'hF, 1'b1};
        tbl[7] = '{1'b1, 4'h1, 0,   0,  1, 4'h0, 4'h0, 1'b1};
        tbl[8] = '{1'b1, 4'h1, 3,   3,  1, 4'h6, 4'h0, 1'b0};
        tbl[9] = '{1'b1, 4'h1, 2,   0,  1, 4'h0, 4'h0, 1'b1};

        RST = 1'b1; start = 1'b1; abort = 1'b0; mode = 1'b1; seed = 4'h3;
        num_vec = 16'd4; warmup = 16'd0; exp_sig = 4'h0; resp = 4'h0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_stim", 32'(stim), 32'd0);
        chk("rst_signature", 32'(signature), 32'd0);
        chk("rst_vec_idx", 32'(vec_idx), 32'd0);
        start = 1'b0;
        RST   = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        for (int t = 0; t < 10; t++) begin
            run(tbl[t].m, tbl[t].sd, tbl[t].nv, tbl[t].wu, tbl[t].ex, tbl[t].rk, sig);
            chk("tbl_signature", 32'(signature), 32'(tbl[t].esig));
            chk("tbl_pass", 32'(pass), 32'(tbl[t].epass));
        end

        // Abort at vec_idx 5 with a start pulse ignored mid-run.
        mode = 1'b1; seed = 4'h1; num_vec = 16'd16; warmup = 16'd0; exp_sig = 4'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lf = 4'h1;
        ms = 4'h0;
        for (int i = 0; i < 5; i++) begin
            chk("abort_stim", 32'(stim), 32'(lf));
            resp = stim;
            ms = step4(ms, MP) ^ stim;
            lf = step4(lf, LP);
            if (i == 2) begin
                start = 1'b1;
                seed  = 4'h7;
            end
            tick();
            start = 1'b0;
        end
        chk("abort_vec_idx", 32'(vec_idx), 32'd5);
        held = ms;
        chk("abort_sig_before", 32'(signature), 32'(held));
        abort = 1'b1;
        resp  = stim;
        tick();
        abort = 1'b0;
        resp  = 4'h0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_stim_zero", 32'(stim), 32'd0);
        chk("abort_sig_held", 32'(signature), 32'(held));
        $display("abort at vec_idx=5 sig=%h", signature);

        // abort outranks a simultaneous start.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_over_start", 32'(busy), 32'd0);

        // Clean run after abort, against the literal scenario-1 sequence.
        seed = 4'h1; num_vec = 16'd16; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("seq1_stim", 32'(stim), 32'(seq1[i]));
            chk("seq1_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("seq1_done", 32'(done), 32'd1);
        chk("seq1_signature", 32'(signature), 32'd0);
        $display("post-abort run sig=%h done=%0b", signature, done);

        // Reset in the middle of a run.
        exp_sig = 4'h0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            resp = stim;
            tick();
        end
        RST = 1'b1;
        tick();
        RST  = 1'b0;
        resp = 4'h0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_pass", 32'(pass), 32'd0);
        chk("mrst_stim", 32'(stim), 32'd0);
        chk("mrst_signature", 32'(signature), 32'd0);
        chk("mrst_vec_idx", 32'(vec_idx), 32'd0);
        $display("mid-run reset sig=%h vec_idx=%0d", signature, vec_idx);

        for (int t = 0; t < 25; t++) begin
            int nv;
            int wu;
            nv = int'($urandom_range(0, 40));
            wu = int'($urandom_range(0, 44));
            run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), nv, wu,
                4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), sig);
            if ($urandom_range(0, 3) == 0) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("rand_abort_done", 32'(done), 32'd0);
                chk("rand_abort_sig", 32'(signature), 32'(sig));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
